io_uart32: RTL and testbench
============================

Name: io_uart32

Overview:
- Memory-mapped UART peripheral on the CPU IO bus. Responds to the IO read and IO write strobes that the control unit raises for lw/sw to the 0xFFFFFC00 IO window.
- Occupies a 16-byte slot: TX data, RX data, status and baud-divisor registers.
- Serialises bytes from an 8-entry TX FIFO as 8N1 frames and receives 8N1 frames into a holding register.
- Read data is combinational, so a single-cycle lw completes in its own cycle.

Parameters:
- BASE_OFS, 6'h30, value of addr[9:4] that selects this block (byte address 0xFFFFFF00).
- FIFO_DEPTH, 8, TX FIFO entries; power of two.
- BAUD_DIV, 16'd433, reset value of the baud divisor. Bit period = divisor+1 clocks.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- addr  in  10  low address bits [9:0] of the ALU result
- ioread  in  1  IO read strobe, one cycle per lw
- iowrite  in  1  IO write strobe, one cycle per sw
- wdata  in  32  store data
- rdata  out  32  load data; combinational
- uart_txd  out  1  serial TX line; idle high
- uart_rxd  in  1  serial RX line; asynchronous

Behaviour:
- Select: sel = (addr[9:4]==BASE_OFS). Register index = addr[3:2]; addr[1:0] is ignored.
  - 0 TXDATA: write pushes wdata[7:0]; reads as 0.
  - 1 RXDATA: read returns {24'b0, rx_byte}.
  - 2 STATUS: read-only bits below; any write clears the sticky bits [6:4].
  - 3 BAUDDIV: read/write, bits [15:0].
- STATUS bits:
  - [0] tx_empty, [1] tx_full, [2] tx_busy, [3] rx_valid
  - [4] tx_overflow, [5] rx_overrun, [6] rx_frame_err
  - [11:8] tx_count; all other bits 0.
- rdata = 0 whenever !(sel & ioread). Otherwise it is the selected register, combinationally.
- Write side effects commit on the rising clock edge where sel & iowrite.
- The RXDATA read side effect (clear rx_valid) commits on the edge where sel & ioread & index==1.
- Reset values:
  - uart_txd=1; FIFO empty, count 0; all flags 0
  - baud divisor = BAUD_DIV; rx_byte=0; both FSMs idle
  - Reset mid-frame aborts it immediately and drives txd high.
- Baud timer: the TX counter runs 0..div, then wraps; a tick is issued at wrap.
  - Writing BAUDDIV resets both the TX and RX counters.
  - Software writes BAUDDIV only while idle; mid-frame behaviour is unspecified.
- TX FIFO:
  - A push while full with no same-cycle pop is dropped and sets tx_overflow.
  - A push and a pop in the same cycle are both honoured.
- TX FSM: IDLE -> START -> DATA (8 bits, LSB first) -> STOP -> IDLE, or straight to START if the FIFO is non-empty.
  - In IDLE with the FIFO non-empty: pop into the shifter and restart the baud counter. txd goes low on the next edge.
  - Each state holds exactly div+1 clocks. A frame is 10*(div+1) clocks; back-to-back frames have no idle gap.
  - tx_busy = state != IDLE.
  - txd is registered.
- RX path:
  - 2-flop synchroniser on uart_rxd.
  - In IDLE, a falling edge of the synchronised line starts the half-bit counter. After (div+1)/2 clocks the line is re-checked; if high it is a glitch and the FSM returns to IDLE.
  - Then 8 data samples (LSB first) and 1 stop sample are taken, each div+1 clocks apart.
  - On the stop sample:
    - stop=0 sets rx_frame_err and discards the byte.
    - Otherwise, if rx_valid=1, set rx_overrun and discard the new byte.
    - Otherwise load rx_byte and set rx_valid.
  - If the CPU read clears rx_valid in the same cycle a byte loads, the load wins and rx_valid stays 1.

Optional Feature:
- UART_RX_EN.
- Defined: the RX path above is built.
- Undefined: no RX logic; uart_rxd is ignored.
  - RXDATA reads 0; STATUS[3], [5] and [6] are constant 0.
  - The TX path is unchanged.

Test Plan:
- Reset, then read STATUS (addr 0x308) -> rdata=0x00000001 and txd=1. Read BAUDDIV -> 433.
- Write BAUDDIV=3, then TXDATA=0xA5 -> txd pattern 0,1,0,1,0,0,1,0,1,1, each level 4 clocks, 40 clocks total. tx_busy is 1 during the frame.
- With BAUDDIV=3, write 9 bytes back-to-back -> tx_count peaks at 8 and tx_overflow=1. The 8 accepted bytes are sent with no idle gap. A write to STATUS clears bit 4.
- Access with addr[9:4]!=0x30, both read and write -> rdata=0 and no state change.
- UART_RX_EN, BAUDDIV=3: drive frame 0x3C on rxd -> rx_valid=1 and RXDATA=0x3C. The read clears rx_valid. A second frame before the read sets rx_overrun, and rx_byte stays 0x3C.
- UART_RX_EN: frame with stop bit 0 -> rx_frame_err=1, rx_valid=0. A 1-clock low glitch on rxd leaves the FSM idle and sets no flags.

Source files
------------

// File: rtl/io_uart32.sv
// io_uart32 - memory-mapped 8N1 UART on the CPU IO bus (byte address 0xFFFFFF00 slot).
//
// Register map (index = addr[3:2], addr[1:0] ignored):
//   0 TXDATA  W: push wdata[7:0] into the TX FIFO; reads 0
//   1 RXDATA  R: {24'b0, rx_byte}; a read clears rx_valid
//   2 STATUS  R: [0] tx_empty [1] tx_full [2] tx_busy [3] rx_valid [4] tx_overflow
//                [5] rx_overrun [6] rx_frame_err [11:8] tx_count; any write clears [6:4]
//   3 BAUDDIV RW: [15:0], bit period = div+1 clocks; a write restarts both baud counters
//
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   addr[9:0]         low address bits; block selected when addr[9:4] == BASE_OFS
//   ioread, iowrite   one-cycle IO strobes
//   wdata[31:0]       store data
//   rdata[31:0]       combinational load data, 0 unless selected and ioread
//   uart_txd          registered serial output, idle high
//   uart_rxd          asynchronous serial input
//
// Build option: define UART_RX_EN to build the receiver. Without it uart_rxd is ignored and
// the RX status bits and RXDATA read as 0.
module io_uart32 #(
  parameter logic [5:0]  BASE_OFS   = 6'h30,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] BAUD_DIV   = 16'd433
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  addr,
  input  logic        ioread,
  input  logic        iowrite,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        uart_txd,
  input  logic        uart_rxd
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Bus decode
  logic       sel, rd_en, wr_en, wr_tx, wr_stat, wr_baud;
  logic [1:0] idx;
  assign sel     = (addr[9:4] == BASE_OFS);
  assign idx     = addr[3:2];
  assign rd_en   = sel & ioread;
  assign wr_en   = sel & iowrite;
  assign wr_tx   = wr_en & (idx == 2'd0);
  assign wr_stat = wr_en & (idx == 2'd2);
  assign wr_baud = wr_en & (idx == 2'd3);

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:16]};

  logic [15:0] baud_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        baud_q <= BAUD_DIV;
    else if (wr_baud) baud_q <= wdata[15:0];
  end

  // TX FIFO
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            fifo_empty, fifo_full, push_ok, pop, tx_overflow_q;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CntW'(FIFO_DEPTH));
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign push_ok    = wr_tx & (~fifo_full | pop);

  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= wdata[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      tx_overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q <= cnt_q + CntW'(push_ok) - CntW'(pop);
      if (wr_tx & fifo_full & ~pop) tx_overflow_q <= 1'b1;
      else if (wr_stat)             tx_overflow_q <= 1'b0;
    end
  end

  // TX FSM
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d, tx_tick, tx_busy;

  assign tx_tick = (tx_cnt_q == baud_q);
  assign tx_busy = (tx_state_q != TxIdle);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_tick ? '0 : tx_cnt_q + 16'd1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    pop        = 1'b0;
    case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_shift_d = fifo_mem[rd_ptr_q];
          tx_state_d = TxStart;
          txd_d      = 1'b0;
        end
      end
      TxStart: if (tx_tick) begin
        tx_state_d = TxData;
        tx_bit_d   = '0;
        txd_d      = tx_shift_q[0];
      end
      TxData: if (tx_tick) begin
        if (tx_bit_q == 3'd7) begin
          tx_state_d = TxStop;
          txd_d      = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          txd_d      = tx_shift_q[1];
        end
      end
      TxStop: if (tx_tick) begin
        // Chain straight into the next start bit so bursts have no idle gap.
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_shift_d = fifo_mem[rd_ptr_q];
          tx_state_d = TxStart;
          txd_d      = 1'b0;
        end else begin
          tx_state_d = TxIdle;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
    if (wr_baud) tx_cnt_d = '0;
  end

  assign uart_txd = txd_q;

  // RX path
  logic [7:0] rx_byte;
  logic       rx_valid, rx_overrun, rx_frame_err;

`ifdef UART_RX_EN
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  rx_state_e   rx_state_q, rx_state_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rd_rx, rx_tick, rx_half_done;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;
  logic [16:0] rx_half;

  assign rd_rx        = rd_en & (idx == 2'd1);
  assign rx_tick      = (rx_cnt_q == baud_q);
  assign rx_half      = ({1'b0, baud_q} + 17'd1) >> 1;
  assign rx_half_done = (({1'b0, rx_cnt_q} + 17'd1) >= rx_half);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_s1_q    <= uart_rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    rx_ferr_d  = rx_ferr_q;
    if (rd_rx) rx_valid_d = 1'b0;
    if (wr_stat) begin
      rx_ovr_d  = 1'b0;
      rx_ferr_d = 1'b0;
    end
    case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_prev_q & ~rx_s2_q) rx_state_d = RxStart;
      end
      RxStart: if (rx_half_done) begin
        // Mid start bit: a high line here means the falling edge was a glitch.
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RxIdle : RxData;
      end
      RxData: if (rx_tick) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end
      RxStop: if (rx_tick) begin
        rx_cnt_d   = '0;
        rx_state_d = RxIdle;
        if (!rx_s2_q)        rx_ferr_d = 1'b1;
        else if (rx_valid_q) rx_ovr_d  = 1'b1;
        else begin
          // Placed after the read-clear so a same-cycle load keeps rx_valid set.
          rx_byte_d  = rx_shift_q;
          rx_valid_d = 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
    if (wr_baud) rx_cnt_d = '0;
  end

  assign rx_byte      = rx_byte_q;
  assign rx_valid     = rx_valid_q;
  assign rx_overrun   = rx_ovr_q;
  assign rx_frame_err = rx_ferr_q;
`else
  logic unused_rxd;
  assign unused_rxd   = uart_rxd;
  assign rx_byte      = '0;
  assign rx_valid     = 1'b0;
  assign rx_overrun   = 1'b0;
  assign rx_frame_err = 1'b0;
`endif

  // Read mux
  logic [31:0] status;
  assign status = {20'b0, 4'(cnt_q), 1'b0, rx_frame_err, rx_overrun, tx_overflow_q,
                   rx_valid, tx_busy, fifo_full, fifo_empty};

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (idx)
        2'd0:    rdata = '0;
        2'd1:    rdata = {24'b0, rx_byte};
        2'd2:    rdata = status;
        default: rdata = {16'b0, baud_q};
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart32.sv
`timescale 1ns/1ps
module tb_io_uart32;
  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  addr;
  logic        ioread, iowrite;
  logic [31:0] wdata, rdata;
  logic        uart_txd, uart_rxd;

  io_uart32 dut (
    .clock   (clock),
    .reset   (reset),
    .addr    (addr),
    .ioread  (ioread),
    .iowrite (iowrite),
    .wdata   (wdata),
    .rdata   (rdata),
    .uart_txd(uart_txd),
    .uart_rxd(uart_rxd)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    @(negedge clock);
    addr = a; wdata = d; iowrite = 1'b1; ioread = 1'b0;
    @(posedge clock); #1;
    iowrite = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, output logic [31:0] d);
    @(negedge clock);
    addr = a; ioread = 1'b1; iowrite = 1'b0;
    #1 d = rdata;
    @(posedge clock); #1;
    ioread = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] s;
    int k = 0;
    do begin
      rd(10'h308, s);
      k++;
    end while ((s[2:0] != 3'b001) && (k < 2000));
    check(name, {29'b0, s[2:0]}, 32'h1);
  endtask

  // Line monitor: decodes 8N1 frames on uart_txd by sampling each bit mid-period.
  int          mon_p = 434;
  logic [7:0]  mon_q[$];
  int unsigned mon_t[$];
  int          mon_ferr = 0;
  initial begin
    int unsigned t0;
    logic [7:0]  b;
    logic        okf;
    forever begin
      @(negedge clock);
      if (reset === 1'b0 && uart_txd === 1'b0) begin
        t0  = cyc;
        okf = 1'b1;
        repeat (mon_p / 2) @(negedge clock);
        if (uart_txd !== 1'b0) okf = 1'b0;
        for (int k = 0; k < 8; k++) begin
          repeat (mon_p) @(negedge clock);
          b[k] = uart_txd;
        end
        repeat (mon_p) @(negedge clock);
        if (uart_txd !== 1'b1) okf = 1'b0;
        mon_q.push_back(b);
        mon_t.push_back(t0);
        if (!okf) mon_ferr++;
      end
    end
  end

  task automatic mon_clear();
    mon_q.delete();
    mon_t.delete();
    mon_ferr = 0;
  endtask

  // Drive one frame on uart_rxd, each bit held cur_p clocks.
  int cur_p = 4;
  task automatic rx_frame(input logic [7:0] b, input logic stopb);
    logic [9:0] bits;
    bits = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      uart_rxd = bits[i];
      repeat (cur_p - 1) @(negedge clock);
    end
    @(negedge clock);
    uart_rxd = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  typedef struct {
    logic [9:0]  a;
    logic        r;
    logic        w;
    logic [31:0] wd;
    logic [31:0] exp;
    string       nm;
  } vec_t;
  vec_t vecs[16];

  logic [7:0]  exp_q[$];
  logic [31:0] s;
  logic [7:0]  bv;
  logic [9:0]  pat;
  int          k, dv, nb;

  initial begin
    vecs[0]  = '{10'h308, 1'b1, 1'b0, 32'h0,        32'h1,   "rst_status"};
    vecs[1]  = '{10'h30C, 1'b1, 1'b0, 32'h0,        32'h1B1, "rst_baud"};
    vecs[2]  = '{10'h304, 1'b1, 1'b0, 32'h0,        32'h0,   "rst_rxdata"};
    vecs[3]  = '{10'h300, 1'b1, 1'b0, 32'h0,        32'h0,   "txdata_reads0"};
    vecs[4]  = '{10'h30C, 1'b0, 1'b1, 32'hFFFF0003, 32'h0,   "baud_wr_noread"};
    vecs[5]  = '{10'h30C, 1'b1, 1'b0, 32'h0,        32'h3,   "baud_rd"};
    vecs[6]  = '{10'h30E, 1'b1, 1'b0, 32'h0,        32'h3,   "baud_rd_lowbits"};
    vecs[7]  = '{10'h20C, 1'b0, 1'b1, 32'h7,        32'h0,   "oow_baud_wr"};
    vecs[8]  = '{10'h20C, 1'b1, 1'b0, 32'h0,        32'h0,   "oow_baud_rd"};
    vecs[9]  = '{10'h30C, 1'b1, 1'b0, 32'h0,        32'h3,   "baud_unchanged"};
    vecs[10] = '{10'h100, 1'b1, 1'b1, 32'h55,       32'h0,   "oow_tx_rdwr"};
    vecs[11] = '{10'h3F8, 1'b1, 1'b0, 32'h0,        32'h0,   "oow_status_rd"};
    vecs[12] = '{10'h308, 1'b1, 1'b0, 32'h0,        32'h1,   "status_no_push"};
    vecs[13] = '{10'h30C, 1'b0, 1'b0, 32'h0,        32'h0,   "no_strobe"};
    vecs[14] = '{10'h308, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0,   "status_wr"};
    vecs[15] = '{10'h308, 1'b1, 1'b0, 32'h0,        32'h1,   "status_readonly"};

    reset = 1'b1; addr = '0; ioread = 1'b0; iowrite = 1'b0; wdata = '0; uart_rxd = 1'b1;
    repeat (3) @(negedge clock);
    check("txd_in_reset", {31'b0, uart_txd}, 32'h1);
    reset = 1'b0;
    @(negedge clock); #1;
    check("txd_after_reset", {31'b0, uart_txd}, 32'h1);

    // Register-access vectors
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      addr = vecs[i].a; ioread = vecs[i].r; iowrite = vecs[i].w; wdata = vecs[i].wd;
      #1 check(vecs[i].nm, rdata, vecs[i].exp);
      @(posedge clock); #1;
      ioread = 1'b0; iowrite = 1'b0;
    end
    mon_p = 4;

    // Exact TX waveform for 0xA5 at div=3
    mon_clear();
    pat = {2'b11, 8'hA5} << 1;  // stop, data, start (bit 0 = start = 0)
    @(negedge clock);
    addr = 10'h300; wdata = 32'hA5; iowrite = 1'b1;
    @(posedge clock); #1;
    iowrite = 1'b0;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (uart_txd === 1'b1 && k < 20);
    check("a5_start_latency", 32'(k), 32'd2);
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clock);
      addr = 10'h308; ioread = 1'b1;
      #1;
      if (i % 4 == 0) check($sformatf("a5_txd_bit%0d", i / 4), {31'b0, uart_txd},
                            {31'b0, pat[i / 4]});
      else if (uart_txd !== pat[i / 4])
        check($sformatf("a5_txd_hold%0d", i), {31'b0, uart_txd}, {31'b0, pat[i / 4]});
      if (i == 0 || i == 39) check($sformatf("a5_busy%0d", i), {31'b0, rdata[2]}, 32'h1);
    end
    @(negedge clock); #1;
    check("a5_txd_idle", {31'b0, uart_txd}, 32'h1);
    check("a5_status_idle", rdata, 32'h1);
    ioread = 1'b0;
    check("a5_mon_count", 32'(mon_q.size()), 32'd1);
    if (mon_q.size() > 0) check("a5_mon_byte", {24'b0, mon_q[0]}, 32'hA5);

    // Overflow: 9 back-to-back writes while a frame is in flight
    mon_clear();
    exp_q.delete();
    wr(10'h300, 32'h11);
    exp_q.push_back(8'h11);
    repeat (3) @(posedge clock);
    for (int i = 0; i < 9; i++) begin
      bv = 8'h20 + 8'(i);
      wr(10'h300, {24'b0, bv});
      if (i < 8) exp_q.push_back(bv);
    end
    rd(10'h308, s);
    check("ovf_status", s, 32'h816);
    wr(10'h308, 32'h0);
    rd(10'h308, s);
    check("ovf_cleared", s, 32'h806);
    wait_idle("ovf_idle_timeout");
    check("ovf_frames", 32'(mon_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      check($sformatf("ovf_byte%0d", i), {24'b0, mon_q[i]}, {24'b0, exp_q[i]});
      if (i > 0) check($sformatf("ovf_gap%0d", i), mon_t[i] - mon_t[i - 1], 32'd40);
    end
    check("ovf_framing", 32'(mon_ferr), 32'd0);

    // Randomized bursts against a byte-queue model
    for (int r = 0; r < 6; r++) begin
      dv = $urandom_range(1, 5);
      wr(10'h30C, 32'(dv));
      mon_p = dv + 1;
      rd(10'h30C, s);
      check($sformatf("rnd%0d_baud", r), s, 32'(dv));
      mon_clear();
      exp_q.delete();
      nb = $urandom_range(1, 8);
      for (int i = 0; i < nb; i++) begin
        bv = 8'($urandom);
        exp_q.push_back(bv);
        wr(10'h300, {$urandom_range(0, 255), bv} & 32'h00FFFFFF);
        repeat ($urandom_range(0, 3)) @(posedge clock);
      end
      wait_idle($sformatf("rnd%0d_idle_timeout", r));
      check($sformatf("rnd%0d_frames", r), 32'(mon_q.size()), 32'(nb));
      for (int i = 0; i < nb && i < mon_q.size(); i++)
        check($sformatf("rnd%0d_byte%0d", r, i), {24'b0, mon_q[i]}, {24'b0, exp_q[i]});
      check($sformatf("rnd%0d_framing", r), 32'(mon_ferr), 32'd0);
    end

    wr(10'h30C, 32'h3);
    cur_p = 4;
`ifdef UART_RX_EN
    begin
      logic       m_valid, m_ovr, m_ferr, stb;
      logic [7:0] m_byte;
      rx_frame(8'h3C, 1'b1);
      rd(10'h308, s); check("rx_valid_set", s, 32'h9);
      rd(10'h304, s); check("rx_data", s, 32'h3C);
      rd(10'h308, s); check("rx_valid_clr", s, 32'h1);
      rx_frame(8'h3C, 1'b1);
      rx_frame(8'h55, 1'b1);
      rd(10'h308, s); check("rx_overrun", s, 32'h29);
      rd(10'h304, s); check("rx_overrun_keep", s, 32'h3C);
      wr(10'h308, 32'h0);
      rd(10'h308, s); check("rx_sticky_clr", s, 32'h1);
      rx_frame(8'hAA, 1'b0);
      rd(10'h308, s); check("rx_frame_err", s, 32'h41);
      wr(10'h308, 32'h0);
      @(negedge clock); uart_rxd = 1'b0;
      @(negedge clock); uart_rxd = 1'b1;
      repeat (20) @(negedge clock);
      rd(10'h308, s); check("rx_glitch", s, 32'h1);
      rx_frame(8'h81, 1'b1);
      rd(10'h304, s); check("rx_after_glitch", s, 32'h81);
      m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_byte = 8'h81;
      for (int r = 0; r < 8; r++) begin
        bv  = 8'($urandom);
        stb = ($urandom_range(0, 3) != 0);
        rx_frame(bv, stb);
        if (!stb)        m_ferr = 1'b1;
        else if (m_valid) m_ovr = 1'b1;
        else begin m_byte = bv; m_valid = 1'b1; end
        rd(10'h308, s);
        check($sformatf("rxr%0d_flags", r), {25'b0, s[6:0]},
              {25'b0, m_ferr, m_ovr, 1'b0, m_valid, 3'b001});
        if ($urandom_range(0, 1) == 1) begin
          rd(10'h304, s);
          check($sformatf("rxr%0d_data", r), s, {24'b0, m_byte});
          m_valid = 1'b0;
        end
      end
    end
`else
    rx_frame(8'h3C, 1'b1);
    rd(10'h308, s); check("norx_status", s, 32'h1);
    rd(10'h304, s); check("norx_rxdata", s, 32'h0);
    check("norx_txd", {31'b0, uart_txd}, 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
